// File: rtl/hex_word_sender.sv
// Prints a latched word as uppercase ASCII hex (MSB nibble first) followed by CR LF.
// Define HEX_PREFIX_EN to start every line with "0x".
module hex_word_sender #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  start,
  output logic                  ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  done
);

  localparam int unsigned Nibbles = DATA_WIDTH / 4;
  localparam int unsigned CntW    = (Nibbles > 1) ? $clog2(Nibbles) : 1;

  typedef enum logic [2:0] {
    StIdle,
`ifdef HEX_PREFIX_EN
    StPfx0,
    StPfx1,
`endif
    StDigit,
    StCr,
    StLf
  } state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   word_q, word_d;
  logic                    ready_q, ready_d;
  logic                    tx_valid_q, tx_valid_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    done_q, done_d;
  logic                    xfer;

  function automatic logic [7:0] bin2ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

  assign xfer = tx_valid_q & tx_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          word_d = data_in;
          cnt_d  = CntW'(Nibbles - 1);
`ifdef HEX_PREFIX_EN
          state_d = StPfx0;
`else
          state_d = StDigit;
`endif
        end
      end
`ifdef HEX_PREFIX_EN
      StPfx0: if (xfer) state_d = StPfx1;
      StPfx1: if (xfer) state_d = StDigit;
`endif
      StDigit: begin
        if (xfer) begin
          if (cnt_q != '0) cnt_d = cnt_q - CntW'(1);
          else             state_d = StCr;
        end
      end
      StCr: if (xfer) state_d = StLf;
      StLf: begin
        if (xfer) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state, so a stall keeps them frozen.
  always_comb begin
    ready_d    = (state_d == StIdle);
    tx_valid_d = (state_d != StIdle);
    tx_data_d  = 8'h00;
    unique case (state_d)
`ifdef HEX_PREFIX_EN
      StPfx0:  tx_data_d = 8'h30;
      StPfx1:  tx_data_d = 8'h78;
`endif
      StDigit: tx_data_d = bin2ascii(word_d[{cnt_d, 2'b00} +: 4]);
      StCr:    tx_data_d = 8'h0D;
      StLf:    tx_data_d = 8'h0A;
      default: tx_data_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      word_q     <= '0;
      ready_q    <= 1'b1;
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      ready_q    <= ready_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      done_q     <= done_d;
    end
  end

  assign ready    = ready_q;
  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign done     = done_q;

endmodule

// File: tb/tb_hex_word_sender.sv
// Bench for hex_word_sender: queue-based line model checked every cycle plus literal lines.
module tb_hex_word_sender;

`ifdef HEX_PREFIX_EN
  localparam bit Pfx = 1'b1;
`else
  localparam bit Pfx = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data32;
  logic        start32, tx_ready32, ready32, tx_valid32, done32;
  logic [7:0]  tx_data32;
  logic [7:0]  data8;
  logic        start8, tx_ready8, ready8, tx_valid8, done8;
  logic [7:0]  tx_data8;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  logic [7:0] m32_q[$];
  logic [7:0] m8_q[$];
  logic       m32_done = 1'b0;
  logic       m8_done  = 1'b0;
  logic [7:0] got32[$];
  logic [7:0] got8[$];

  always #5 clk = ~clk;

  hex_word_sender #(.DATA_WIDTH(32)) u_dut32 (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data32),
    .start    (start32),
    .ready    (ready32),
    .tx_data  (tx_data32),
    .tx_valid (tx_valid32),
    .tx_ready (tx_ready32),
    .done     (done32)
  );

  hex_word_sender #(.DATA_WIDTH(8)) u_dut8 (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data8),
    .start    (start8),
    .ready    (ready8),
    .tx_data  (tx_data8),
    .tx_valid (tx_valid8),
    .tx_ready (tx_ready8),
    .done     (done8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] hex_char(input int n);
    if (n < 10) return 8'(48 + n);
    return 8'(65 + n - 10);
  endfunction

  // Model: a pending line is a queue of characters; non-empty queue means busy.
  always @(posedge clk) begin
    m32_done <= !rst && m32_q.size() == 1 && tx_ready32;
    if (rst) m32_q.delete();
    else if (m32_q.size() != 0) begin
      if (tx_ready32) void'(m32_q.pop_front());
    end else if (start32) begin
      if (Pfx) begin m32_q.push_back(8'h30); m32_q.push_back(8'h78); end
      for (int i = 7; i >= 0; i--) m32_q.push_back(hex_char(int'((data32 >> (4 * i)) & 32'hF)));
      m32_q.push_back(8'h0D);
      m32_q.push_back(8'h0A);
    end
  end

  always @(posedge clk) begin
    m8_done <= !rst && m8_q.size() == 1 && tx_ready8;
    if (rst) m8_q.delete();
    else if (m8_q.size() != 0) begin
      if (tx_ready8) void'(m8_q.pop_front());
    end else if (start8) begin
      if (Pfx) begin m8_q.push_back(8'h30); m8_q.push_back(8'h78); end
      for (int i = 1; i >= 0; i--) m8_q.push_back(hex_char(int'((data8 >> (4 * i)) & 8'hF)));
      m8_q.push_back(8'h0D);
      m8_q.push_back(8'h0A);
    end
  end

  // Compare and record transfers mid-cycle; inputs change only just after posedge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("ready32", ready32, m32_q.size() == 0);
      check("valid32", tx_valid32, m32_q.size() != 0);
      if (m32_q.size() != 0) check("data32", tx_data32, m32_q[0]);
      check("done32", done32, m32_done);
      check("ready8", ready8, m8_q.size() == 0);
      check("valid8", tx_valid8, m8_q.size() != 0);
      if (m8_q.size() != 0) check("data8", tx_data8, m8_q[0]);
      check("done8", done8, m8_done);
    end
    if (!rst) begin
      if (tx_valid32 && tx_ready32) got32.push_back(tx_data32);
      if (tx_valid8 && tx_ready8) got8.push_back(tx_data8);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_line(input string name, input logic [7:0] got[$],
                            input logic [7:0] body[$]);
    logic [7:0] full[$];
    full = body;
    if (Pfx) begin full.push_front(8'h78); full.push_front(8'h30); end
    check({name, "_len"}, got.size(), full.size());
    for (int i = 0; i < full.size() && i < got.size(); i++) check(name, got[i], full[i]);
  endtask

  task automatic wait_done32(input string name);
    int n = 0;
    while (done32 !== 1'b1 && n < 200) begin tick(); n++; end
    check({name, "_timeout"}, n < 200, 1);
  endtask

  // Cycle-exact run with tx_ready=1: character k in cycle k, done in the cycle after the last.
  task automatic run_timed(input string name, input logic [31:0] d, input logic [7:0] body[$]);
    logic [7:0] full[$];
    full = body;
    if (Pfx) begin full.push_front(8'h78); full.push_front(8'h30); end
    data32 = d; start32 = 1'b1; tx_ready32 = 1'b1;
    for (int c = 1; c <= full.size() + 1; c++) begin
      tick();
      start32 = 1'b0;
      if (c <= full.size()) begin
        check({name, "_valid"}, tx_valid32, 1);
        check({name, "_char"}, tx_data32, full[c-1]);
      end
      check({name, "_done"}, done32, c == full.size() + 1);
      check({name, "_ready"}, ready32, c == full.size() + 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] lit[$];
    int n;
    int done_cnt;
    rst = 1'b1; start32 = 1'b0; start8 = 1'b0; data32 = '0; data8 = '0;
    tx_ready32 = 1'b1; tx_ready8 = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_ready", ready32, 1);
    check("rst_valid", tx_valid32, 0);
    check("rst_data", tx_data32, 8'h00);
    check("rst_done", done32, 0);
    check("rst_ready8", ready8, 1);
    rst = 1'b0;
    tick();

    // Line 1: DEADBEEF, exact per-cycle timing.
    lit = {8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
    run_timed("t1", 32'hDEADBEEF, lit);

    // Back-to-back: start in the done cycle.
    got32.delete();
    data32 = 32'h0123ABCD; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    check("t7_valid", tx_valid32, 1);
    check("t7_first", tx_data32, 8'h30);
    wait_done32("t7");
    lit = {8'h30, 8'h31, 8'h32, 8'h33, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
    check_line("t7_line", got32, lit);
    tick();

    // Backpressure: tx_ready 1,0,0 repeating.
    got32.delete();
    data32 = 32'hDEADBEEF; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    n = 0;
    while (done32 !== 1'b1 && n < 100) begin tx_ready32 = (n % 3 == 0); tick(); n++; end
    check("t2_timeout", n < 100, 1);
    tx_ready32 = 1'b1;
    lit = {8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
    check_line("t2_line", got32, lit);
    tick();

    // 8-bit instance; data_in changes after acceptance.
    got8.delete();
    data8 = 8'h0A; start8 = 1'b1;
    tick();
    start8 = 1'b0; data8 = 8'hFF;
    n = 0;
    while (done8 !== 1'b1 && n < 50) begin tick(); n++; end
    check("t3_timeout", n < 50, 1);
    lit = {8'h30, 8'h41, 8'h0D, 8'h0A};
    check_line("t3_line", got8, lit);
    tick();

    // start pulses while busy are ignored.
    got32.delete();
    done_cnt = 0;
    data32 = 32'h12345678; start32 = 1'b1;
    tick();
    start32 = 1'b0; data32 = 32'hFFFFFFFF;
    for (int c = 1; c <= 20; c++) begin
      if (done32 === 1'b1) done_cnt++;
      start32 = (c == 3 || c == 6);
      tick();
    end
    start32 = 1'b0;
    check("t4_done_cnt", done_cnt, 1);
    lit = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h0D, 8'h0A};
    check_line("t4_line", got32, lit);

    // Reset during the third digit, then a clean line.
    data32 = 32'h89ABCDEF; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    repeat (2 + (Pfx ? 2 : 0)) tick();
    check("t5_third", tx_data32, 8'h41);
    rst = 1'b1;
    tick();
    check("t5_valid", tx_valid32, 0);
    check("t5_ready", ready32, 1);
    check("t5_done", done32, 0);
    rst = 1'b0;
    got32.delete();
    data32 = 32'h00000001; start32 = 1'b1;
    tick();
    start32 = 1'b0;
    wait_done32("t5b");
    lit = {8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h31, 8'h0D, 8'h0A};
    check_line("t5_line", got32, lit);
    tick();

    // CAFE line, exact timing (prefix build: done in cycle 13).
    lit = {8'h30, 8'h30, 8'h30, 8'h30, 8'h43, 8'h41, 8'h46, 8'h45, 8'h0D, 8'h0A};
    run_timed("t6", 32'h0000CAFE, lit);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
